// File: rtl/conc_pkg.sv
// Shared definitions for the concolic stimulus player and trace recorder.
// Record layout is identical to the player's opcode layout, so stimulus
// and response words can live in the same address space.
package conc_pkg;

    localparam int REC_W     = 6;
    localparam int NL_W      = 4;
    localparam int NLOSS_BIT = 5;
    localparam int NL_LSB    = 1;
    localparam int SPK_BIT   = 0;
    localparam int DEPTH_DEF = 1001;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        FULL,
        DONE
    } state_e;

    // Assemble one record from the b12 outputs
    function automatic logic [REC_W-1:0] pack_rec(input logic            nloss,
                                                  input logic [NL_W-1:0] nl,
                                                  input logic            spk);
        logic [REC_W-1:0] r;
        r               = '0;
        r[NLOSS_BIT]    = nloss;
        r[NL_LSB +: NL_W] = nl;
        r[SPK_BIT]      = spk;
        return r;
    endfunction

endpackage

// File: rtl/conc_rle_packer.sv
// Run-length packer for the trace recorder (built only with CONC_TRACE_RLE_EN).
// Holds the current run value and length; emit/emit_rec/emit_run are
// combinational so the recorder can register the write and bump its counter
// on the same edge. emit_run is the run length minus one.
module conc_rle_packer
    import conc_pkg::*;
#(
    parameter int RUN_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [REC_W-1:0] in_rec,
    input  logic             close,
    output logic             emit,
    output logic [REC_W-1:0] emit_rec,
    output logic [RUN_W-1:0] emit_run,
    output logic             held
);

    logic             run_vld, nxt_vld;
    logic [REC_W-1:0] run_rec, nxt_rec;
    logic [RUN_W-1:0] run_cnt, nxt_cnt, cnt_inc;

    assign cnt_inc = run_cnt + 1'b1;
    assign held    = run_vld;

    // Decide whether this edge closes a run and what the held run becomes
    always_comb begin
        emit     = 1'b0;
        emit_rec = run_rec;
        emit_run = run_cnt;
        nxt_vld  = run_vld;
        nxt_rec  = run_rec;
        nxt_cnt  = run_cnt;
        if (in_vld) begin
            if (run_vld && (in_rec != run_rec)) begin
                // Differing sample: flush the old run, start a new one.
                // A coincident close leaves the new run for the next edge.
                emit    = 1'b1;
                nxt_rec = in_rec;
                nxt_cnt = '0;
                nxt_vld = 1'b1;
            end else if (run_vld) begin
                emit_run = cnt_inc;
                if ((cnt_inc == {RUN_W{1'b1}}) || close) begin
                    emit    = 1'b1;
                    nxt_vld = 1'b0;
                end else begin
                    nxt_cnt = cnt_inc;
                end
            end else begin
                emit_rec = in_rec;
                emit_run = '0;
                if (close) begin
                    emit    = 1'b1;
                    nxt_vld = 1'b0;
                end else begin
                    nxt_vld = 1'b1;
                    nxt_rec = in_rec;
                    nxt_cnt = '0;
                end
            end
        end else if (close && run_vld) begin
            emit    = 1'b1;
            nxt_vld = 1'b0;
        end
    end

    // Run register and counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_vld <= 1'b0;
            run_rec <= '0;
            run_cnt <= '0;
        end else begin
            run_vld <= nxt_vld;
            run_rec <= nxt_rec;
            run_cnt <= nxt_cnt;
        end
    end

endmodule

// File: rtl/conc_trace_recorder.sv
// Concolic trace recorder: samples {nloss, nl, speaker} each enabled cycle
// and writes the records, in order, into a trace RAM write port.
// Optional macro CONC_TRACE_RLE_EN merges identical consecutive samples
// into one record carrying a repeat count on wr_run.
module conc_trace_recorder
    import conc_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RUN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic              nloss,
    input  logic [NL_W-1:0]   nl,
    input  logic              speaker,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [REC_W-1:0]  wr_data,
    output logic [RUN_W-1:0]  wr_run,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH);

    state_e           state;
    logic [REC_W-1:0] smp;
    logic             room;
    logic             take;
    logic             emit;
    logic [REC_W-1:0] emit_rec;
    logic             pending;

    assign smp  = pack_rec(nloss, nl, speaker);
    // Once DEPTH records exist nothing else may be sampled or written
    assign room = (count < LAST_CNT);
    assign take = (state == CAPTURE) && enable && room;

`ifdef CONC_TRACE_RLE_EN
    logic             close;
    logic [RUN_W-1:0] emit_run;
    logic [RUN_W-1:0] run_q;

    // Close the held run on flush, and keep closing while draining
    assign close = (((state == CAPTURE) && flush) || (state == DRAIN)) && room;

    conc_rle_packer #(.RUN_W(RUN_W)) u_packer (
        .clock    (clock),
        .reset    (reset),
        .in_vld   (take),
        .in_rec   (smp),
        .close    (close),
        .emit     (emit),
        .emit_rec (emit_rec),
        .emit_run (emit_run),
        .held     (pending)
    );

    // Repeat-count field travels alongside wr_data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            run_q <= '0;
        else if (emit)
            run_q <= emit_run;
    end

    assign wr_run = run_q;
`else
    // One record per sample; nothing can be held back
    assign emit     = take;
    assign emit_rec = smp;
    assign pending  = 1'b0;
    assign wr_run   = '0;
`endif

    // Capture FSM plus registered write port and status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            count   <= '0;
            full    <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr_en <= emit;
            if (emit) begin
                wr_addr <= count[ADDR_W-1:0];
                wr_data <= emit_rec;
                count   <= count + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (enable) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (count == LAST_CNT) begin
                        state <= FULL;
                        full  <= 1'b1;
                        done  <= 1'b1;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Full wins over a normal drain completion
                    if (count == LAST_CNT) begin
                        state <= FULL;
                        full  <= 1'b1;
                        done  <= 1'b1;
                    end else if (!pending) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                FULL, DONE: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/conc_trace_recorder.md
Name: conc_trace_recorder

Overview:
Response-side counterpart of the concolic stimulus player. The player reads 6-bit opcodes from a RAM and drives the b12 DUT. This block samples the DUT outputs {nloss, nl[3:0], speaker} each clock and packs them into 6-bit records. It writes the records, in order, into a trace RAM through a simple write port, so stimulus and response share one word format and one address space.

Parameters:
DEPTH, 1001, number of trace RAM words (addresses 0..DEPTH-1)
ADDR_W, 10, width of wr_addr; ceil(log2(DEPTH))
RUN_W, 4, width of the run-length field; used only when CONC_TRACE_RLE_EN is defined

Ports:
clock  input  1  single clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  capture qualifier; 1 = sample this cycle, 0 = pause
flush  input  1  single-cycle pulse; end capture, drain pending data, go to DONE
nloss  input  1  DUT output sampled into record bit 5
nl  input  4  DUT output sampled into record bits 4:1
speaker  input  1  DUT output sampled into record bit 0
wr_en  output  1  trace RAM write strobe, one cycle per record
wr_addr  output  ADDR_W  trace RAM write address
wr_data  output  6  record {nloss, nl, speaker}
wr_run  output  RUN_W  repeat count minus 1 for wr_data; constant 0 without CONC_TRACE_RLE_EN
count  output  ADDR_W+1  records written so far
full  output  1  DEPTH records written; capture stopped
done  output  1  capture ended by flush or by full

Behaviour:
- Reset (reset=0, async): state IDLE; wr_en=0, wr_addr=0, wr_data=0, wr_run=0, count=0, full=0, done=0; the sample register and the run register are cleared.
- FSM states and transitions:
  - IDLE -> CAPTURE on the first cycle with enable=1 after reset release.
  - CAPTURE -> FULL when count reaches DEPTH.
  - CAPTURE -> DRAIN on flush.
  - DRAIN -> DONE once nothing is pending.
  - FULL and DONE are terminal until reset.
  - flush in IDLE -> DONE directly with count=0.
- Sampling: in CAPTURE with enable=1, the sample register captures {nloss, nl, speaker} at the edge.
- Write latency, no RLE: every sampled record produces wr_en=1 on the next cycle, with wr_addr=count and wr_data=the sampled value. count increments on that edge. Latency is one cycle. Back-to-back samples produce back-to-back writes.
- enable=0 in CAPTURE: no sample is taken and no new write is started; the write for a sample already taken still completes.
- flush in the same cycle as a sample: the sample is taken and written. DRAIN lasts until that write completes, then DONE. flush in IDLE gives done=1 one cycle later.
- Full: on the write that makes count=DEPTH, full=1 and done=1 are asserted on the following cycle. Further samples are dropped and wr_en stays 0. There is no wrap-around; addresses never exceed DEPTH-1.
- full and flush together: full takes precedence; the pending write is still performed only if count<DEPTH.
- wr_en is a single-cycle pulse per record and is never asserted in IDLE, FULL or DONE.
- flush or enable asserted while reset=0 is ignored.

Optional Feature:
CONC_TRACE_RLE_EN
- Defined: consecutive identical samples merge into one record with wr_run=N-1, where N is the number of identical samples. A run is emitted one cycle after any of the following:
  - a sample differing from the held run;
  - the run reaching 2^RUN_W samples;
  - flush, if a run is held.
- Defined: the differing sample starts the new run. enable=0 pauses the run without closing it.
- Not defined: one record per sample; wr_run is tied to 0 and no run register exists.

Decomposition:
- Shared package conc_pkg holds:
  - REC_W=6;
  - the record field offsets (NLOSS_BIT=5, NL_LSB=1, SPK_BIT=0), shared with the stimulus player's opcode layout;
  - the state enum {IDLE, CAPTURE, DRAIN, FULL, DONE};
  - the default DEPTH=1001.
- One sub-module: conc_rle_packer. It holds the run register and counter and emits a record strobe. It is instantiated only under CONC_TRACE_RLE_EN.

Test Plan:
- Basic capture: release reset, enable=1, drive 3 distinct samples 6'h21, 6'h02, 6'h3F -> writes at addr 0,1,2 with matching data, each one cycle after its sample; count=3.
- Pause: enable=0 for 4 cycles mid-stream -> no wr_en during the pause; addresses remain contiguous after resume.
- Flush: flush coincident with the 5th sample -> 5th record written at addr 4; done=1 on the next cycle; no further writes.
- Full: DEPTH=4, enable held high for 10 cycles -> exactly 4 writes at addr 0..3; full=1 and done=1; wr_addr never reaches 4.
- Mid-operation reset: reset low during CAPTURE -> all outputs return to 0 immediately (async); after release, capture restarts at addr 0.
- RLE (macro defined): 5x 6'h10, then 6'h11, then flush -> two writes: {6'h10, run=4} at addr 0, then {6'h11, run=0} at addr 1. A run of 17x 6'h10 with RUN_W=4 -> {6'h10, run=15} followed by {6'h10, run=0}.
